// File: rtl/clap_light_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clap_light_ctrl_if
// Purpose  : Valid/ready handshake carrying clap counts from the clap
//            detector into clap_light_ctrl.
// Signals  : claps_data  - clap count word (CLAPS_WIDTH bits)
//            claps_valid - claps_data is valid (source -> sink)
//            claps_ready - sink can accept a count (sink -> source)
// Modports : master = clap count source, slave = clap_light_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface clap_light_ctrl_if #(
    parameter int CLAPS_WIDTH = 16
) ();
    logic [CLAPS_WIDTH-1:0] claps_data;
    logic                   claps_valid;
    logic                   claps_ready;

    modport master (output claps_data, output claps_valid, input claps_ready);
    modport slave  (input claps_data, input claps_valid, output claps_ready);
endinterface
`default_nettype wire

// File: rtl/clap_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clap_light_ctrl
// Purpose  : Decodes clap counts into light commands (all-off, on, off,
//            toggle, select channel) and drives a bank of light outputs,
//            each with an optional auto-off timer.
// Ports    : clock       - system clock, rising edge
//            reset       - synchronous, active-high reset
//            claps       - clap count handshake (slave side)
//            light_state - bit i drives light i (1 = on)
//            sel_chan    - currently selected channel
//            cmd_err     - one-cycle pulse when a count matched no command
// Revision : 1.0 - initial release
// ============================================================================
module clap_light_ctrl #(
    parameter int CLAPS_WIDTH     = 16,
    parameter int NUM_LIGHTS      = 4,
    parameter int ALL_OFF_VAL     = 1,
    parameter int ON_VAL          = 2,
    parameter int OFF_VAL         = 3,
    parameter int TOGGLE_VAL      = 4,
    parameter int SELECT_BASE     = 5,
    parameter int TIMER_WIDTH     = 24,
    parameter int AUTO_OFF_CYCLES = 0
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    clap_light_ctrl_if.slave           claps,
    output logic [NUM_LIGHTS-1:0]      light_state,
    output logic [((NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1)-1:0] sel_chan,
    output logic                       cmd_err
);

    localparam int SEL_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;

    localparam logic [CLAPS_WIDTH-1:0] c_ALL_OFF  = CLAPS_WIDTH'(ALL_OFF_VAL);
    localparam logic [CLAPS_WIDTH-1:0] c_ON       = CLAPS_WIDTH'(ON_VAL);
    localparam logic [CLAPS_WIDTH-1:0] c_OFF      = CLAPS_WIDTH'(OFF_VAL);
    localparam logic [CLAPS_WIDTH-1:0] c_TOGGLE   = CLAPS_WIDTH'(TOGGLE_VAL);
    localparam logic [CLAPS_WIDTH-1:0] c_SEL_BASE = CLAPS_WIDTH'(SELECT_BASE);
    // One extra bit so SELECT_BASE+NUM_LIGHTS cannot wrap at the top of the range.
    localparam logic [CLAPS_WIDTH:0]   c_SEL_LO   = (CLAPS_WIDTH+1)'(SELECT_BASE);
    localparam logic [CLAPS_WIDTH:0]   c_SEL_HI   = (CLAPS_WIDTH+1)'(SELECT_BASE + NUM_LIGHTS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ready;
    logic [CLAPS_WIDTH-1:0] r_cmd_buf;
    logic [NUM_LIGHTS-1:0]  r_light;
    logic [NUM_LIGHTS-1:0]  w_light_nxt;
    logic [SEL_W-1:0]       r_sel;
    logic [SEL_W-1:0]       w_sel_val;
    logic                   r_err;
    logic                   w_accept;
    logic                   w_in_range;
    logic                   w_all_off;
    logic                   w_on;
    logic                   w_off;
    logic                   w_toggle;
    logic                   w_select;
    logic                   w_bad;

    assign claps.claps_ready = r_ready;
    assign light_state       = r_light;
    assign sel_chan          = r_sel;
    assign cmd_err           = r_err;

    assign w_accept   = (r_state == S_IDLE) && r_ready && claps.claps_valid;
    assign w_in_range = ({1'b0, r_cmd_buf} >= c_SEL_LO) && ({1'b0, r_cmd_buf} < c_SEL_HI);
    assign w_sel_val  = SEL_W'(r_cmd_buf - c_SEL_BASE);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command decode; the if/else chain sets priority when values collide.
    always_comb begin
        w_all_off = 1'b0;
        w_on      = 1'b0;
        w_off     = 1'b0;
        w_toggle  = 1'b0;
        w_select  = 1'b0;
        w_bad     = 1'b0;
        if (r_state == S_EXEC) begin
            if      (r_cmd_buf == c_ALL_OFF) w_all_off = 1'b1;
            else if (r_cmd_buf == c_ON)      w_on      = 1'b1;
            else if (r_cmd_buf == c_OFF)     w_off     = 1'b1;
            else if (r_cmd_buf == c_TOGGLE)  w_toggle  = 1'b1;
            else if (w_in_range)             w_select  = 1'b1;
            else                             w_bad     = 1'b1;
        end
    end

    // ready is registered from the next state so it is low during EXEC
    // and also low in the reset cycle itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_cmd_buf <= '0;
            r_light   <= '0;
            r_sel     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) r_cmd_buf <= claps.claps_data;
            r_light <= w_light_nxt;
            r_err   <= w_bad;
            if (w_select) r_sel <= w_sel_val;
        end
    end

    for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_chan
        logic w_hit;
        logic w_expire;
        logic w_next;

        assign w_hit = (r_sel == SEL_W'(i));

        // A command aimed at this channel overrides a same-edge expiry.
        always_comb begin
            w_next = r_light[i];
            if      (w_all_off)         w_next = 1'b0;
            else if (w_hit && w_on)     w_next = 1'b1;
            else if (w_hit && w_off)    w_next = 1'b0;
            else if (w_hit && w_toggle) w_next = ~r_light[i];
            else if (w_expire)          w_next = 1'b0;
        end
        assign w_light_nxt[i] = w_next;

        if (AUTO_OFF_CYCLES > 0) begin : g_timer
            localparam logic [TIMER_WIDTH-1:0] c_LOAD = TIMER_WIDTH'(AUTO_OFF_CYCLES);
            localparam logic [TIMER_WIDTH-1:0] c_ONE  = TIMER_WIDTH'(1);
            logic [TIMER_WIDTH-1:0] r_timer;

            // Loaded at the switch-on edge E, reaches 1 at E+AUTO_OFF_CYCLES-1,
            // so the light drops on edge E+AUTO_OFF_CYCLES.
            assign w_expire = r_light[i] && (r_timer == c_ONE);

            always_ff @(posedge clock) begin
                if (reset)                  r_timer <= '0;
                else if (w_all_off)         r_timer <= '0;
                else if (w_hit && w_on)     r_timer <= c_LOAD;
                else if (w_hit && w_off)    r_timer <= '0;
                else if (w_hit && w_toggle) r_timer <= r_light[i] ? '0 : c_LOAD;
                else if (r_light[i] && (r_timer != '0)) r_timer <= r_timer - c_ONE;
            end
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clap_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clap_light_ctrl
// Purpose  : Self-checking bench for clap_light_ctrl (NUM_LIGHTS=4,
//            AUTO_OFF_CYCLES=10) with an edge-level reference model that
//            tracks lights by absolute expiry edge number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clap_light_ctrl;
    localparam int CW = 16;
    localparam int NL = 4;
    localparam int A  = 10;
    localparam int SW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NL-1:0] light_state;
    logic [SW-1:0] sel_chan;
    logic          cmd_err;

    clap_light_ctrl_if #(.CLAPS_WIDTH(CW)) bus ();

    clap_light_ctrl #(.CLAPS_WIDTH(CW), .NUM_LIGHTS(NL), .AUTO_OFF_CYCLES(A)) dut (
        .clock       (clock),
        .reset       (reset),
        .claps       (bus.slave),
        .light_state (light_state),
        .sel_chan    (sel_chan),
        .cmd_err     (cmd_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    bit          m_light[NL];
    int          m_exp[NL];     // edge number of scheduled auto-off, 0 = none
    int          m_sel;
    bit          m_err;
    bit          m_ready;
    bit          m_pend;
    int unsigned m_cmd;

    function automatic logic [NL-1:0] model_lights();
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = m_light[i];
        return r;
    endfunction

    function automatic void model_edge(bit rst, bit v, logic [CW-1:0] d);
        bit touched[NL];
        bit nl[NL];
        if (rst) begin
            for (int i = 0; i < NL; i++) begin m_light[i] = 0; m_exp[i] = 0; end
            m_sel = 0; m_err = 0; m_ready = 0; m_pend = 0; m_cmd = 0;
            return;
        end
        m_err = 0;
        for (int i = 0; i < NL; i++) begin touched[i] = 0; nl[i] = m_light[i]; end
        if (m_pend) begin
            m_pend  = 0;
            m_ready = 1;
            if (m_cmd == 1) begin
                for (int i = 0; i < NL; i++) begin nl[i] = 0; m_exp[i] = 0; touched[i] = 1; end
            end else if (m_cmd == 2) begin
                nl[m_sel] = 1; m_exp[m_sel] = cyc + A; touched[m_sel] = 1;
            end else if (m_cmd == 3) begin
                nl[m_sel] = 0; m_exp[m_sel] = 0; touched[m_sel] = 1;
            end else if (m_cmd == 4) begin
                nl[m_sel] = !m_light[m_sel];
                m_exp[m_sel] = nl[m_sel] ? cyc + A : 0;
                touched[m_sel] = 1;
            end else if (m_cmd >= 5 && m_cmd < 5 + NL) begin
                m_sel = int'(m_cmd) - 5;
            end else begin
                m_err = 1;
            end
        end else if (m_ready && v) begin
            m_pend  = 1;
            m_cmd   = d;
            m_ready = 0;
        end else begin
            m_ready = 1;
        end
        for (int i = 0; i < NL; i++)
            if (!touched[i] && m_light[i] && m_exp[i] == cyc) begin nl[i] = 0; m_exp[i] = 0; end
        for (int i = 0; i < NL; i++) m_light[i] = nl[i];
    endfunction

    // One clock edge: DUT and model both see the inputs present at the edge.
    task automatic step();
        @(posedge clock);
        cyc++;
        model_edge(reset, bus.claps_valid, bus.claps_data);
        #1;
    endtask

    // Presents a count and returns just after the accepting edge.
    task automatic send(input int v);
        bit rdy;
        bit got;
        got = 0;
        bus.claps_data  = CW'(v);
        bus.claps_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rdy = bus.claps_ready;
            step();
            if (rdy) begin got = 1; break; end
        end
        bus.claps_valid = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL send_accept value=%0d accepted=0 required=1", v); end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.claps_valid = 1'b0; bus.claps_data = '0;
        step();
        total++; if (bus.claps_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.claps_ready); end
        total++; if (light_state !== 4'b0000) begin bad++; $display("FAIL reset_light got=%b exp=0000", light_state); end
        total++; if (sel_chan !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_chan); end
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cmd_err); end
        reset = 1'b0;
        step();
        total++; if (bus.claps_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", bus.claps_ready); end
    endtask

    task automatic test_select_on();
        send(6);
        total++; if (bus.claps_ready !== 1'b0) begin bad++; $display("FAIL ready_low_exec got=%b exp=0", bus.claps_ready); end
        step();
        total++; if (sel_chan !== 2'd1) begin bad++; $display("FAIL select_ch1 got=%0d exp=1", sel_chan); end
        total++; if (bus.claps_ready !== 1'b1) begin bad++; $display("FAIL ready_back got=%b exp=1", bus.claps_ready); end
        send(2);
        total++; if (bus.claps_ready !== 1'b0) begin bad++; $display("FAIL ready_low_on got=%b exp=0", bus.claps_ready); end
        step();
        total++; if (light_state !== 4'b0010) begin bad++; $display("FAIL on_ch1 got=%b exp=0010", light_state); end
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) begin
                total++; if (light_state !== 4'b0010) begin bad++; $display("FAIL ch1_before_expiry got=%b exp=0010", light_state); end
            end
        end
        total++; if (light_state !== 4'b0000) begin bad++; $display("FAIL ch1_expired got=%b exp=0000", light_state); end
    endtask

    task automatic test_toggle();
        send(8); step();
        total++; if (sel_chan !== 2'd3) begin bad++; $display("FAIL select_ch3 got=%0d exp=3", sel_chan); end
        send(4); step();
        total++; if (light_state !== 4'b1000) begin bad++; $display("FAIL toggle1 got=%b exp=1000", light_state); end
        send(4); step();
        total++; if (light_state !== 4'b0000) begin bad++; $display("FAIL toggle2 got=%b exp=0000", light_state); end
        send(4); step();
        total++; if (light_state !== 4'b1000) begin bad++; $display("FAIL toggle3 got=%b exp=1000", light_state); end
        send(1); step();
        total++; if (light_state !== 4'b0000) begin bad++; $display("FAIL all_off got=%b exp=0000", light_state); end
    endtask

    task automatic test_errors();
        int vals[3] = '{0, 9, 65535};
        foreach (vals[j]) begin
            send(vals[j]); step();
            total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_pulse val=%0d got=%b exp=1", vals[j], cmd_err); end
            total++; if (light_state !== 4'b0000 || sel_chan !== 2'd3) begin bad++; $display("FAIL err_nochange val=%0d light=%b sel=%0d exp=0000/3", vals[j], light_state, sel_chan); end
            step();
            total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_width val=%0d got=%b exp=0", vals[j], cmd_err); end
        end
    endtask

    task automatic test_auto_off();
        int e;
        send(5); step();
        send(2); step(); e = cyc;
        total++; if (light_state !== 4'b0001) begin bad++; $display("FAIL ch0_on got=%b exp=0001", light_state); end
        while (cyc < e + 8) step();
        bus.claps_data = CW'(2); bus.claps_valid = 1'b1;
        step();                              // accept at E+9
        bus.claps_valid = 1'b0;
        step();                              // ON executes on the expiry edge E+10
        total++; if (light_state !== 4'b0001) begin bad++; $display("FAIL refresh_on_expiry got=%b exp=0001", light_state); end
        while (cyc < e + 19) step();
        total++; if (light_state !== 4'b0001) begin bad++; $display("FAIL refreshed_hold got=%b exp=0001", light_state); end
        step();
        total++; if (light_state !== 4'b0000) begin bad++; $display("FAIL refreshed_off got=%b exp=0000", light_state); end
        // ch0 and ch2 on at different edges, each expires on its own schedule
        send(2); step(); e = cyc;
        send(7); step();
        send(2); step();
        total++; if (light_state !== 4'b0101 || cyc != e + 4) begin bad++; $display("FAIL two_on got=%b/%0d exp=0101/%0d", light_state, cyc, e + 4); end
        while (cyc < e + 10) step();
        total++; if (light_state !== 4'b0100) begin bad++; $display("FAIL ch0_indep_off got=%b exp=0100", light_state); end
        while (cyc < e + 13) step();
        total++; if (light_state !== 4'b0100) begin bad++; $display("FAIL ch2_hold got=%b exp=0100", light_state); end
        step();
        total++; if (light_state !== 4'b0000) begin bad++; $display("FAIL ch2_indep_off got=%b exp=0000", light_state); end
    endtask

    task automatic test_reset_exec();
        send(2);
        reset = 1'b1;
        step();
        total++; if (light_state !== 4'b0000 || bus.claps_ready !== 1'b0) begin bad++; $display("FAIL reset_exec light=%b ready=%b exp=0000/0", light_state, bus.claps_ready); end
        reset = 1'b0;
        step();
        total++; if (light_state !== 4'b0000 || bus.claps_ready !== 1'b1 || sel_chan !== 2'd0) begin bad++; $display("FAIL after_reset_exec light=%b ready=%b sel=%0d exp=0000/1/0", light_state, bus.claps_ready, sel_chan); end
    endtask

    task automatic test_random();
        bit rdy;
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 80) == 0);
            if (!bus.claps_valid) begin
                bus.claps_valid = ($urandom_range(0, 3) != 0);
                bus.claps_data  = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 10));
            end
            rdy = bus.claps_ready;
            step();
            if (rdy || reset) bus.claps_valid = 1'b0;
            total++;
            if (light_state !== model_lights() || sel_chan !== SW'(m_sel) || cmd_err !== m_err || bus.claps_ready !== m_ready) begin
                bad++;
                $display("FAIL random cyc=%0d light=%b sel=%0d err=%b ready=%b exp=%b/%0d/%b/%b",
                         cyc, light_state, sel_chan, cmd_err, bus.claps_ready, model_lights(), m_sel, m_err, m_ready);
            end
        end
        reset = 1'b0;
        bus.claps_valid = 1'b0;
    endtask

    initial begin
        bus.claps_valid = 1'b0;
        bus.claps_data  = '0;
        test_reset();
        test_select_on();
        test_toggle();
        test_errors();
        test_auto_off();
        test_reset_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
